// File: rtl/fp_clamp_seq_pkg.sv
// Shared types and helpers for the float clamp sequencer.
package fp_clamp_seq_pkg;

  localparam int DATA_W = 32;

  // Engine operation select as driven on mm_minmax.
  localparam logic MM_MAX = 1'b0;
  localparam logic MM_MIN = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MAX_REQ  = 3'd1,
    ST_MAX_WAIT = 3'd2,
    ST_MIN_REQ  = 3'd3,
    ST_MIN_WAIT = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  // Watchdog counter width: wide enough for the timeout, never below 4 bits.
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/fp_clamp_seq.sv
// Float clamp sequencer: q = min(max(x, lo), hi) using a shared start/done
// minmax engine, with a watchdog that falls back to q = x on engine stall.
module fp_clamp_seq
  import fp_clamp_seq_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic              c,
  input  logic              rst,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] hi,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] q,
  output logic              clamped_lo,
  output logic              clamped_hi,
  output logic              err,
  output logic [DATA_W-1:0] mm_a,
  output logic [DATA_W-1:0] mm_b,
  output logic              mm_minmax,
  output logic              mm_start,
  input  logic [DATA_W-1:0] mm_q,
  input  logic              mm_done
);

  localparam int               CNT_W    = cnt_width(TIMEOUT);
  // The REQ cycle counts as elapsed cycle 1, so the last waiting cycle
  // holds TIMEOUT-1 and DONE lands exactly TIMEOUT cycles after mm_start.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] x_l_q, x_l_d;
  logic [DATA_W-1:0] hi_l_q, hi_l_d;
  logic [DATA_W-1:0] s1_q, s1_d;
  logic [DATA_W-1:0] mm_a_q, mm_a_d;
  logic [DATA_W-1:0] mm_b_q, mm_b_d;
  logic              mm_minmax_q, mm_minmax_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic              clamped_lo_q, clamped_lo_d;
  logic              clamped_hi_q, clamped_hi_d;
  logic              err_q, err_d;

  // Next-state, operand staging, watchdog and result capture.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    x_l_d        = x_l_q;
    hi_l_d       = hi_l_q;
    s1_d         = s1_q;
    mm_a_d       = mm_a_q;
    mm_b_d       = mm_b_q;
    mm_minmax_d  = mm_minmax_q;
    q_d          = q_q;
    clamped_lo_d = clamped_lo_q;
    clamped_hi_d = clamped_hi_q;
    err_d        = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_l_d       = x;
          hi_l_d      = hi;
          // Operands are staged now so they are already stable in MAX_REQ.
          mm_a_d      = x;
          mm_b_d      = lo;
          mm_minmax_d = MM_MAX;
          state_d     = ST_MAX_REQ;
        end
      end

      ST_MAX_REQ: begin
        cnt_d   = CNT_ONE;
        state_d = ST_MAX_WAIT;
      end

      ST_MAX_WAIT: begin
        if (mm_done) begin
          s1_d        = mm_q;
          mm_a_d      = mm_q;
          mm_b_d      = hi_l_q;
          mm_minmax_d = MM_MIN;
          state_d     = ST_MIN_REQ;
        end else if (cnt_q == CNT_LAST) begin
          q_d          = x_l_q;
          err_d        = 1'b1;
          clamped_lo_d = 1'b0;
          clamped_hi_d = 1'b0;
          state_d      = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_MIN_REQ: begin
        cnt_d   = CNT_ONE;
        state_d = ST_MIN_WAIT;
      end

      ST_MIN_WAIT: begin
        if (mm_done) begin
          q_d          = mm_q;
          clamped_lo_d = (s1_q != x_l_q);
          clamped_hi_d = (mm_q != s1_q);
          err_d        = 1'b0;
          state_d      = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          q_d          = x_l_q;
          err_d        = 1'b1;
          clamped_lo_d = 1'b0;
          clamped_hi_d = 1'b0;
          state_d      = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state and all visible outputs; cleared by reset.
  always_ff @(posedge c) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      mm_a_q       <= '0;
      mm_b_q       <= '0;
      mm_minmax_q  <= 1'b0;
      q_q          <= '0;
      clamped_lo_q <= 1'b0;
      clamped_hi_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mm_a_q       <= mm_a_d;
      mm_b_q       <= mm_b_d;
      mm_minmax_q  <= mm_minmax_d;
      q_q          <= q_d;
      clamped_lo_q <= clamped_lo_d;
      clamped_hi_q <= clamped_hi_d;
      err_q        <= err_d;
    end
  end

  // Internal data latches; only read after being written in the same operation.
  always_ff @(posedge c) begin
    x_l_q  <= x_l_d;
    hi_l_q <= hi_l_d;
    s1_q   <= s1_d;
  end

  assign mm_start   = (state_q == ST_MAX_REQ) || (state_q == ST_MIN_REQ);
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done       = (state_q == ST_DONE);
  assign mm_a       = mm_a_q;
  assign mm_b       = mm_b_q;
  assign mm_minmax  = mm_minmax_q;
  assign q          = q_q;
  assign clamped_lo = clamped_lo_q;
  assign clamped_hi = clamped_hi_q;
  assign err        = err_q;

endmodule
